// File: rtl/game_pkg.sv
// Shared constants for the reaction-time game: clocking, debounce window
// and key polarity.
package game_pkg;
  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned N_KEYS          = 2;
  localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam logic        KEY_PRESSED     = 1'b1;
endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, consecutive-sample debounce
// counter, debounced level and a combinational "press qualifies now" strobe.
module key_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic state,
  output logic press
);
  import game_pkg::*;

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          flip;

  // Terminal count with a mismatch: the level is accepted on this edge.
  assign flip  = (s2 != state) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press = flip && (s2 == KEY_PRESSED);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
      if (s2 == state) begin
        cnt <= '0;
      end else if (flip) begin
        state <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// Button front end: per-key debounce channels plus registered press pulses.
// Define KEY_CHORD_REJECT_EN to suppress presses made while another key is
// held or qualifies in the same cycle.
module key_conditioner #(
  parameter int unsigned N_KEYS          = game_pkg::N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_edge
);
  import game_pkg::*;

  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] edge_block;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[i]),
      .state (key_state[i]),
      .press (press[i])
    );
  end

`ifdef KEY_CHORD_REJECT_EN
  // Any other key already down, or rising alongside, cancels this press.
  always_comb begin
    edge_block = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      edge_block[i] = |((key_state | press) & ~(N_KEYS'(1) << i));
    end
  end
`else
  assign edge_block = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      key_edge <= '0;
    end else begin
      key_edge <= press & ~edge_block;
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4, N_KEYS=2.
module tb_key_conditioner;
  localparam int unsigned DC  = 4;
  localparam int unsigned LAT = DC + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic [1:0] key_state;
  logic [1:0] key_edge;

  int unsigned cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [1:0]  val;
    int unsigned at;
  } exp_t;
  exp_t expq[$];

  key_conditioner #(
    .N_KEYS          (2),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_state (key_state),
    .key_edge  (key_edge)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change driven now lands before the next edge; pulse is seen LAT edges later.
  task automatic expect_edge(input logic [1:0] v);
    exp_t e;
    e.val = v;
    e.at  = cyc + LAT;
    expq.push_back(e);
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    checks++;
    if (key_state !== exp) begin
      errors++;
      $display("FAIL %s: key_state=%b expected %b (cycle %0d)", name, key_state, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key_edge !== 2'b00) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_edge: key_edge=%b expected 00 (cycle %0d)", key_edge, cyc);
      end else begin
        e = expq.pop_front();
        if (key_edge !== e.val || cyc != e.at) begin
          errors++;
          $display("FAIL edge: key_edge=%b at cycle %0d, expected %b at cycle %0d",
                   key_edge, cyc, e.val, e.at);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    key_n = 2'b11;
    tick(3);
    check_state("in_reset", 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if ({key_state, key_edge} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle: state/edge=%b expected 0000", {key_state, key_edge});
      end
    end

    // Clean press of key 0
    key_n = 2'b10;
    expect_edge(2'b01);
    tick(LAT - 1);
    check_state("press_early", 2'b00);
    tick(1);
    check_state("press_accept", 2'b01);
    tick(1);
    check_state("press_hold", 2'b01);
    checks++;
    if (key_edge !== 2'b00) begin
      errors++;
      $display("FAIL edge_drop: key_edge=%b expected 00", key_edge);
    end

    // Release of key 0
    key_n = 2'b11;
    tick(LAT - 1);
    check_state("release_early", 2'b01);
    tick(1);
    check_state("release_accept", 2'b00);
    tick(4);

    // Bounce: low 3, high 1, then low held
    key_n = 2'b10;
    tick(3);
    key_n = 2'b11;
    tick(1);
    key_n = 2'b10;
    expect_edge(2'b01);
    tick(LAT - 1);
    check_state("bounce_early", 2'b00);
    tick(1);
    check_state("bounce_accept", 2'b01);
    key_n = 2'b11;
    tick(LAT + 2);
    check_state("bounce_release", 2'b00);

    // Both keys in the same cycle
    key_n = 2'b00;
`ifndef KEY_CHORD_REJECT_EN
    expect_edge(2'b11);
`endif
    tick(LAT);
    check_state("chord_state", 2'b11);
    key_n = 2'b11;
    tick(LAT + 2);
    check_state("chord_release", 2'b00);

    // Key 1 pressed while key 0 is already held
    key_n = 2'b10;
    expect_edge(2'b01);
    tick(LAT + 2);
    key_n = 2'b00;
`ifndef KEY_CHORD_REJECT_EN
    expect_edge(2'b10);
`endif
    tick(LAT);
    check_state("held_then_k1", 2'b11);
    key_n = 2'b11;
    tick(LAT + 2);
    check_state("held_release", 2'b00);

    // Reset mid-count with key 0 held throughout
    key_n = 2'b10;
    tick(4);
    rst = 1'b1;
    tick(2);
    check_state("mid_reset", 2'b00);
    rst = 1'b0;
    expect_edge(2'b01);
    tick(LAT - 1);
    check_state("post_reset_early", 2'b00);
    tick(1);
    check_state("post_reset_accept", 2'b01);
    key_n = 2'b11;
    tick(LAT + 4);
    check_state("final_release", 2'b00);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL missing_edges: %0d expected pulses never seen, expected 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input front end for the reaction-time game. Takes the raw, asynchronous, active-low push-buttons and produces the clean per-key level `key_state` and the single-cycle press pulse `key_edge` that the game controller consumes. Each key gets a 2-flop synchronizer, a consecutive-sample debounce counter and a rising-edge detector. All outputs are registered.

## Interface
- `N_KEYS`, 2: number of buttons; bit i of every bus is key i.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples needed to accept a level change (10 ms at 50 MHz). Must be ≥ 1.
- `clk`  in  1: system clock, 50 MHz; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `key_n`  in  N_KEYS: raw buttons; 0 = pressed; asynchronous to `clk`.
- `key_state`  out  N_KEYS: debounced level; 1 = pressed.
- `key_edge`  out  N_KEYS: one-cycle pulse on each debounced press (0→1 of `key_state`).

## Operation
- Synchronizer per key: `s1 <= ~key_n[i]`, `s2 <= s1`. Only `s2` is used downstream.
- Debounce per key: the counter has width clog2(DEBOUNCE_CYCLES+1).
  - `s2 == key_state[i]`: counter is cleared to 0. A glitch shorter than DEBOUNCE_CYCLES is therefore discarded completely.
  - `s2 != key_state[i]` and counter == DEBOUNCE_CYCLES-1: `key_state[i]` toggles and the counter clears.
  - Otherwise the counter increments.
  - The counter never wraps, because it clears at the terminal count.
- Edge detect: `key_edge[i]` is asserted for exactly the one cycle in which `key_state[i]` is first 1. Releases produce no pulse.
- Keys are fully independent unless KEY_CHORD_REJECT_EN is defined (see Configuration).
- Reset values:
  - `s1`, `s2`, `key_state`, `key_edge`, all counters = 0.
  - 0 means "released", regardless of pin level.
- Reset mid-debounce: the partial count is lost and no edge is produced.
- Key held through reset release: it is debounced as a fresh press, and `key_edge` fires DEBOUNCE_CYCLES+2 cycles after `rst` deasserts.

## Timing
- Press latency: the raw level changes before clock edge E, and `key_state` and `key_edge` are visible after edge E+DEBOUNCE_CYCLES+1. That is 2 synchronizer edges plus DEBOUNCE_CYCLES mismatch samples, the first of which coincides with the `s2` update edge counted as E+1.
- Release latency: identical. `key_edge` stays 0.
- Minimum press/release spacing for two distinct edges: 2·DEBOUNCE_CYCLES cycles.
- Bounce rule: a bounce during the count restarts the latency from the last bounce.
- Simultaneous presses on different keys that qualify in the same cycle raise both `key_edge` bits in that cycle, unless chord rejection is enabled.

## Configuration
- `KEY_CHORD_REJECT_EN` defined (anti-mash):
  - `key_edge[i]` is suppressed if any other key's `key_state` is already 1.
  - It is also suppressed if any other key qualifies a press in the same cycle; in that case all concurrent edges are suppressed.
  - `key_state` is unaffected.
  - This stops a player scoring by pressing both buttons at once.
- Not defined: edges are per-key independent, exactly as in Operation.
- Cost: one N_KEYS-wide reduction in the edge path; no added latency.

## Structure
- Shared package `game_pkg`:
  - `CLK_HZ` = 50000000
  - `DEBOUNCE_MS` = 10
  - `N_KEYS` = 2
  - the derived default `DEBOUNCE_CYCLES`
  - the `KEY_PRESSED` = 1 polarity constant
- Sub-module `key_debounce_ch`: one channel (synchronizer, counter, state, raw edge). It is generated N_KEYS times.
- The top level contains only the generate loop and the chord-reject gating.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and N_KEYS=2.
1. Reset with `key_n`=2'b11 → `key_state`=0 and `key_edge`=0 for 20 cycles.
2. `key_n[0]` 1→0, held clean → `key_state[0]`=1 and `key_edge`=2'b01 after exactly 6 edges. `key_edge` drops the next cycle; `key_state` holds.
3. Bounce: `key_n[0]` low 3 cycles, high 1, low held → a single edge, 6 edges after the last transition. No pulse before that.
4. Release of key 0 after a press → `key_state[0]` clears after 6 edges; `key_edge` stays 0.
5. Both keys pressed in the same cycle → without the macro, `key_edge`=2'b11 for one cycle. With KEY_CHORD_REJECT_EN, `key_edge` stays 0 while `key_state`=2'b11. With the macro and key 1 pressed while key 0 is already held, no edge is produced.
6. `rst` pulsed at count 2 of a press, key still held → no edge around reset; the edge appears 6 edges after `rst` deasserts.
